seg_display_driver: RTL and testbench

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_decode.sv | 11 +
 rtl/seg_display_driver.sv | 145 ++++++++++++++
 tb/tb_seg_display_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display driver: DisplayCtrl and
// DisplayData field positions, scan state encoding and the hex glyph table.
package seg_pkg;

  // DisplayCtrl field positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_BLANK_BIT  = 1;
  localparam int CTRL_BRIGHT_LSB = 2;
  localparam int CTRL_BRIGHT_W   = 4;
  localparam int CTRL_RELOAD_LSB = 16;

  // DisplayData field positions
  localparam int DATA_DP_LSB = 16;

  // Active-high segment patterns, bit0 = a ... bit6 = g, for hex digits 0..F
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  // IDLE marks the first enabled cycle, where the prescaler starts from the reload
  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-high seven-segment pattern (pure combinational lookup).
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed seven-segment driver with PWM brightness, leading-zero
// blanking and frame-aligned shadow registers so updates never tear mid-scan.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] DisplayData,
  input  logic [31:0] DisplayCtrl,
  output logic [6:0]  Seg,
  output logic        DP,
  output logic [3:0]  nDigit,
  output logic        FrameDone
);

  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  scan_state_e               state_reg, state_next;
  logic [PRESCALE_WIDTH-1:0] prescaler_reg, prescaler_next;
  logic [PRESCALE_WIDTH-1:0] reload, count_now;
  logic [3:0]                pwm_step_reg, pwm_step_next;
  logic [1:0]                digit_idx_reg, digit_idx_next;

  logic        enable, step_tick, frame_end, shadow_load;
  logic [15:0] shadow_digits_reg;
  logic [3:0]  shadow_dp_reg;
  logic        shadow_en_reg, shadow_blank_reg;
  logic [3:0]  shadow_bright_reg;

  logic [3:0]  blank_mask;
  logic [3:0]  cur_nibble;
  logic [6:0]  cur_seg;
  logic        drive;
  logic        unused_bits;

  assign enable = DisplayCtrl[CTRL_EN_BIT];
  assign reload = DisplayCtrl[CTRL_RELOAD_LSB +: PRESCALE_WIDTH];

  // On the first enabled cycle the prescaler behaves as if already loaded with R
  assign count_now = (state_reg == SCAN_IDLE) ? reload : prescaler_reg;
  assign step_tick = enable && (count_now == '0);
  assign frame_end = step_tick && (pwm_step_reg == 4'hF) && (digit_idx_reg == 2'd3);
  assign FrameDone = frame_end;

  // Scan state and counters
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= SCAN_IDLE;
      prescaler_reg <= '0;
      pwm_step_reg  <= '0;
      digit_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      prescaler_reg <= prescaler_next;
      pwm_step_reg  <= pwm_step_next;
      digit_idx_reg <= digit_idx_next;
    end
  end

  // Next-state: hold everything at zero while disabled, otherwise advance on ticks
  always_comb begin
    state_next     = state_reg;
    prescaler_next = prescaler_reg;
    pwm_step_next  = pwm_step_reg;
    digit_idx_next = digit_idx_reg;
    shadow_load    = 1'b0;
    if (!enable) begin
      state_next     = SCAN_IDLE;
      prescaler_next = '0;
      pwm_step_next  = '0;
      digit_idx_next = '0;
      shadow_load    = 1'b1;
    end else begin
      state_next  = SCAN_RUN;
      shadow_load = frame_end;
      if (step_tick) begin
        prescaler_next = reload;
        pwm_step_next  = pwm_step_reg + 4'd1;
        if (pwm_step_reg == 4'hF) begin
          digit_idx_next = digit_idx_reg + 2'd1;
        end
      end else begin
        prescaler_next = count_now - PRESCALE_WIDTH'(1);
      end
    end
  end

  // Shadow copy of the display inputs; a load only happens while disabled or at a
  // frame boundary, and in both cases the scan that consumes it runs enabled
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shadow_digits_reg <= '0;
      shadow_dp_reg     <= '0;
      shadow_en_reg     <= 1'b0;
      shadow_blank_reg  <= 1'b0;
      shadow_bright_reg <= '0;
    end else if (shadow_load) begin
      shadow_digits_reg <= DisplayData[15:0];
      shadow_dp_reg     <= DisplayData[DATA_DP_LSB +: 4];
      shadow_en_reg     <= 1'b1;
      shadow_blank_reg  <= DisplayCtrl[CTRL_BLANK_BIT];
      shadow_bright_reg <= DisplayCtrl[CTRL_BRIGHT_LSB +: CTRL_BRIGHT_W];
    end
  end

  // A digit is blanked when it and every higher digit are zero; digit0 always shows
  assign blank_mask[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_blank
    assign blank_mask[gi] = shadow_blank_reg && (shadow_digits_reg[15:4*gi] == '0);
  end

  assign cur_nibble = shadow_digits_reg[{digit_idx_reg, 2'b00} +: 4];

  seg_decode u_seg_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  assign drive = enable && shadow_en_reg && (pwm_step_reg <= shadow_bright_reg)
                 && !blank_mask[digit_idx_reg];

  // Registered pin outputs, polarity applied here
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      Seg    <= SEG_OFF;
      DP     <= DP_OFF;
      nDigit <= 4'hF;
    end else if (drive) begin
      Seg    <= SEG_ACTIVE_LOW ? ~cur_seg : cur_seg;
      DP     <= shadow_dp_reg[digit_idx_reg] ^ SEG_ACTIVE_LOW;
      nDigit <= ~(4'b0001 << digit_idx_reg);
    end else begin
      Seg    <= SEG_OFF;
      DP     <= DP_OFF;
      nDigit <= 4'hF;
    end
  end

  assign unused_bits = ^{DisplayData[31:20], DisplayCtrl[15:6], DisplayCtrl[31:16]};

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: a table of one-frame scan vectors
// plus directed sequences for start latency, tear-free update, enable drop and reset.
module tb_seg_display_driver;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] DisplayData;
  logic [31:0] DisplayCtrl;
  logic [6:0]  Seg;
  logic        DP;
  logic [3:0]  nDigit;
  logic        FrameDone;

  int checks = 0;
  int errors = 0;

  seg_display_driver #(
    .PRESCALE_WIDTH (16),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .DisplayData (DisplayData),
    .DisplayCtrl (DisplayCtrl),
    .Seg         (Seg),
    .DP          (DP),
    .nDigit      (nDigit),
    .FrameDone   (FrameDone)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0]      data;
    logic [31:0]      ctrl;
    logic [3:0][7:0]  cnt;   // cycles each digit is driven in one frame
    logic [3:0][6:0]  seg;   // active-high glyph expected per digit
    logic [3:0]       dp;    // DP lit per digit when driven
    int               fd;    // FrameDone pulses expected in the frame window
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [31:0] data, input logic [31:0] ctrl,
                              input logic [3:0][7:0] cnt, input logic [3:0][6:0] seg,
                              input logic [3:0] dp, input int fd);
    vec_t v;
    v.data = data; v.ctrl = ctrl; v.cnt = cnt; v.seg = seg; v.dp = dp; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Present inputs with enable low for two cycles (shadow loads), then raise enable
  task automatic arm(input logic [31:0] data, input logic [31:0] ctrl);
    DisplayData = data;
    DisplayCtrl = ctrl & ~32'h1;
    step();
    step();
    DisplayCtrl = ctrl;
  endtask

  // Scan of data 0x1234, brightness 15, R=0 starting on the current (first enabled) cycle
  task automatic restart_check(input string tag);
    int fd_at;
    fd_at = -1;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (FrameDone && fd_at < 0) fd_at = k;
      if (k == 1) begin
        chk({tag, "_k1_digit"}, 32'(nDigit), 32'hE);
        chk({tag, "_k1_seg"}, 32'(Seg), 32'h19);
      end
      if (k == 16) chk({tag, "_k16_digit"}, 32'(nDigit), 32'hE);
      if (k == 17) chk({tag, "_k17_digit"}, 32'(nDigit), 32'hD);
      if (k == 33) chk({tag, "_k33_digit"}, 32'(nDigit), 32'hB);
      if (k == 49) chk({tag, "_k49_digit"}, 32'(nDigit), 32'h7);
    end
    chk({tag, "_framedone_at"}, 32'(fd_at), 32'd63);
    $display("txn %s: restart scan done, FrameDone at cycle %0d", tag, fd_at);
  endtask

  initial begin
    int cnt_act [4];
    int seg_bad, oh_bad, idle_bad, fd_cnt, fd_at, frame, d;
    int old_bad, new_bad;
    logic [6:0] exp_seg;

    // Reset state
    HRESETn     = 1'b0;
    DisplayData = 32'h1234;
    DisplayCtrl = 32'h0;
    repeat (3) step();
    chk("reset_ndigit", 32'(nDigit), 32'hF);
    chk("reset_seg", 32'(Seg), 32'h7F);
    chk("reset_dp", 32'(DP), 32'h1);
    chk("reset_framedone", 32'(FrameDone), 32'h0);
    $display("txn reset: nDigit=%h Seg=%h DP=%b FrameDone=%b", nDigit, Seg, DP, FrameDone);
    HRESETn = 1'b1;
    step();

    // data, ctrl, counts {d3,d2,d1,d0}, glyphs {d3,d2,d1,d0}, dp, FrameDone pulses
    vecs[0] = mk(32'h0001_1234, 32'h0000_003D, {8'd16, 8'd16, 8'd16, 8'd16},
                 {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0001, 1);
    vecs[1] = mk(32'h0000_1234, 32'h0001_000D, {8'd8, 8'd8, 8'd8, 8'd8},
                 {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, 1);
    vecs[2] = mk(32'h0000_0050, 32'h0000_003F, {8'd0, 8'd0, 8'd16, 8'd16},
                 {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000, 1);
    vecs[3] = mk(32'h000F_0A0B, 32'h0000_001F, {8'd0, 8'd8, 8'd8, 8'd8},
                 {7'h00, 7'h77, 7'h3F, 7'h7C}, 4'b0111, 1);
    vecs[4] = mk(32'h0000_0000, 32'h0002_0003, {8'd0, 8'd0, 8'd0, 8'd3},
                 {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 1);
    vecs[5] = mk(32'hFFF0_CDEF, 32'h0000_FFFD, {8'd16, 8'd16, 8'd16, 8'd16},
                 {7'h39, 7'h5E, 7'h79, 7'h71}, 4'b0000, 1);
    vecs[6] = mk(32'h0001_1234, 32'h0000_003C, {8'd0, 8'd0, 8'd0, 8'd0},
                 {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000, 0);
    vecs[7] = mk(32'h0000_8888, 32'h0000_0039, {8'd15, 8'd15, 8'd15, 8'd15},
                 {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0000, 1);

    for (int vi = 0; vi < 8; vi++) begin
      arm(vecs[vi].data, vecs[vi].ctrl);
      frame = 64 * (int'(vecs[vi].ctrl[31:16]) + 1);
      for (int j = 0; j < 4; j++) cnt_act[j] = 0;
      seg_bad = 0; oh_bad = 0; idle_bad = 0; fd_cnt = 0; fd_at = -1;
      for (int k = 1; k <= frame; k++) begin
        step();
        if (FrameDone) begin
          fd_cnt++;
          if (fd_at < 0) fd_at = k;
        end
        case (nDigit)
          4'hF: begin d = -1; if (Seg !== 7'h7F || DP !== 1'b1) idle_bad++; end
          4'hE: d = 0;
          4'hD: d = 1;
          4'hB: d = 2;
          4'h7: d = 3;
          default: begin d = -1; oh_bad++; end
        endcase
        if (d >= 0) begin
          cnt_act[d]++;
          if (Seg !== ~vecs[vi].seg[d] || DP !== ~vecs[vi].dp[d]) seg_bad++;
        end
      end
      for (int j = 0; j < 4; j++)
        chk($sformatf("v%0d_digit%0d_cycles", vi, j), 32'(cnt_act[j]), 32'(vecs[vi].cnt[j]));
      chk($sformatf("v%0d_seg_dp_errs", vi), 32'(seg_bad), 32'd0);
      chk($sformatf("v%0d_onehot_errs", vi), 32'(oh_bad), 32'd0);
      chk($sformatf("v%0d_idle_errs", vi), 32'(idle_bad), 32'd0);
      chk($sformatf("v%0d_framedone_count", vi), 32'(fd_cnt), 32'(vecs[vi].fd));
      if (vecs[vi].fd > 0)
        chk($sformatf("v%0d_framedone_at", vi), 32'(fd_at), 32'(frame - 1));
      $display("txn vec%0d: data=%h ctrl=%h cycles=%0d/%0d/%0d/%0d framedone=%0d",
               vi, vecs[vi].data, vecs[vi].ctrl, cnt_act[0], cnt_act[1], cnt_act[2],
               cnt_act[3], fd_cnt);
    end

    // First enabled cycle starts at digit0 step0; outputs lag one cycle
    arm(32'h0000_1234, 32'h0000_003D);
    chk("start_k0_digit", 32'(nDigit), 32'hF);
    restart_check("start");

    // Tear-free update: new data appears only after the frame boundary
    arm(32'h0000_1111, 32'h0000_003D);
    old_bad = 0; new_bad = 0; fd_at = -1;
    for (int k = 1; k <= 128; k++) begin
      step();
      if (FrameDone && fd_at < 0) fd_at = k;
      exp_seg = (k <= 64) ? ~7'h06 : ~7'h5B;
      if (nDigit == 4'hF || Seg !== exp_seg) begin
        if (k <= 64) old_bad++;
        else new_bad++;
      end
      if (k == 10) DisplayData = 32'h0000_2222;
    end
    chk("tear_old_frame_errs", 32'(old_bad), 32'd0);
    chk("tear_new_frame_errs", 32'(new_bad), 32'd0);
    chk("tear_framedone_at", 32'(fd_at), 32'd63);
    $display("txn tear: old_errs=%0d new_errs=%0d FrameDone at %0d", old_bad, new_bad, fd_at);

    // Enable drop mid-frame, then restart
    arm(32'h0000_1234, 32'h0000_003D);
    repeat (20) step();
    DisplayCtrl = 32'h0000_003C;
    step();
    chk("drop_ndigit", 32'(nDigit), 32'hF);
    chk("drop_seg", 32'(Seg), 32'h7F);
    chk("drop_dp", 32'(DP), 32'h1);
    chk("drop_framedone", 32'(FrameDone), 32'h0);
    $display("txn drop: nDigit=%h Seg=%h", nDigit, Seg);
    DisplayCtrl = 32'h0000_003D;
    restart_check("drop");

    // Reset pulse mid-frame, then restart
    arm(32'h0000_1234, 32'h0000_003D);
    repeat (30) step();
    HRESETn = 1'b0;
    #1;
    chk("rstpulse_ndigit", 32'(nDigit), 32'hF);
    chk("rstpulse_seg", 32'(Seg), 32'h7F);
    DisplayCtrl = 32'h0000_003C;
    step();
    chk("rstpulse_framedone", 32'(FrameDone), 32'h0);
    $display("txn rstpulse: nDigit=%h Seg=%h", nDigit, Seg);
    HRESETn = 1'b1;
    step();
    DisplayCtrl = 32'h0000_003D;
    restart_check("rstpulse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
